// File: rtl/package_settings_v2.sv
// Shared ADC-path settings and the state encoding of the synthetic pulse generator.
package package_settings_v2;

    localparam int SIZE_ADC_DATA = 14;
    localparam int FRAC_BITS_GEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2
    } pulse_gen_state_t;

endpackage

// File: rtl/pulse_gen_sat_add.sv
// Unsigned saturating adder: clamps the sum to all ones and raises sat when it overflows.
module pulse_gen_sat_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);

    logic [WIDTH:0] sum_full;

    assign sum_full = {1'b0, a} + {1'b0, b};
    assign sat      = sum_full[WIDTH];
    assign sum      = sat ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];

endmodule

// File: rtl/exp_pulse_generator.sv
// Synthetic detector pulse source: linear rise to a latched amplitude, exponential decay,
// registered output offset by a live baseline. Handshake: a request transfers on an edge where start && ready.
module exp_pulse_generator
    import package_settings_v2::*;
#(
    parameter int SIZE_ADC_DATA = package_settings_v2::SIZE_ADC_DATA,
    parameter int FRAC_BITS     = FRAC_BITS_GEN,
    parameter int RISE_SHIFT    = 2,
    parameter bit ALLOW_PILEUP  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     ready,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [3:0]               decay_shift,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    localparam int W = SIZE_ADC_DATA + FRAC_BITS;
    localparam logic [RISE_SHIFT:0] RISE_LAST = (RISE_SHIFT + 1)'((1 << RISE_SHIFT) - 1);

    pulse_gen_state_t        state, state_nxt;
    logic [W-1:0]            acc, acc_nxt;
    logic [RISE_SHIFT:0]     rise_cnt, rise_cnt_nxt;
    logic [SIZE_ADC_DATA-1:0] amp_l;
    logic [3:0]              ds_l;
    logic                    latch;
    logic                    acc_ovf;

    logic [W-1:0]             step;
    logic [W-1:0]             acc_sum;
    logic                     acc_sat;
    logic [SIZE_ADC_DATA-1:0] int_acc;
    logic [SIZE_ADC_DATA-1:0] out_sum;
    logic                     out_sat;
    logic                     accept;

    // Exact division of the amplitude over the rise because RISE_SHIFT <= FRAC_BITS.
    assign step    = {amp_l, {FRAC_BITS{1'b0}}} >> RISE_SHIFT;
    assign int_acc = acc[W-1:FRAC_BITS];

    pulse_gen_sat_add #(.WIDTH(W)) u_acc_add (
        .a   (acc),
        .b   (step),
        .sum (acc_sum),
        .sat (acc_sat)
    );

    pulse_gen_sat_add #(.WIDTH(SIZE_ADC_DATA)) u_out_add (
        .a   (baseline),
        .b   (int_acc),
        .sum (out_sum),
        .sat (out_sat)
    );

    assign ready     = (state == IDLE) || ((state == DECAY) && ALLOW_PILEUP);
    assign busy      = (state != IDLE);
    assign accept    = start && ready;
    assign state_dbg = state;

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        rise_cnt_nxt = rise_cnt;
        latch        = 1'b0;
        acc_ovf      = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt = '0;
                if (accept) begin
                    state_nxt    = RISE;
                    rise_cnt_nxt = '0;
                    latch        = 1'b1;
                end
            end
            RISE: begin
                acc_nxt = acc_sum;
                acc_ovf = acc_sat;
                if (rise_cnt == RISE_LAST) begin
                    state_nxt = DECAY;
                end else begin
                    rise_cnt_nxt = rise_cnt + 1'b1;
                end
            end
            DECAY: begin
                // Pile-up wins over termination and skips this edge's decay step.
                if (accept) begin
                    state_nxt    = RISE;
                    rise_cnt_nxt = '0;
                    latch        = 1'b1;
                end else if (int_acc == '0) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else begin
                    acc_nxt = acc - (acc >> ds_l);
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            rise_cnt    <= '0;
            amp_l       <= '0;
            ds_l        <= '0;
            output_data <= '0;
            overflow    <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            rise_cnt <= rise_cnt_nxt;
            if (latch) begin
                amp_l <= amplitude;
                ds_l  <= decay_shift;
            end
            output_data <= out_sum;
            if (acc_ovf || out_sat) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
